// File: rtl/param_counter.sv
// Parametrised up/down event counter with modulo limit, enable prescaler,
// load/clear, and wrap / saturate / one-shot terminal behaviour.
module param_counter #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}},
    parameter int                PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             done
);

    localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] MODE_SAT  = 2'd1;
    localparam logic [1:0] MODE_ONCE = 2'd2;

    logic [PW-1:0]    pcnt;
    logic [PW-1:0]    pcnt_nxt;
    logic             step;

    logic [WIDTH-1:0] terminal;
    logic             at_term;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] moved;
    logic [WIDTH-1:0] out_step;
    logic             tc_step;
    logic             done_step;
    logic [WIDTH-1:0] load_clamped;

    // Prescaler: a step fires on the enabled cycle that completes a PRESCALE period.
    always_comb begin
        step     = en && (pcnt == P_LAST);
        pcnt_nxt = pcnt;
        if (en) begin
            pcnt_nxt = step ? '0 : pcnt + PW'(1);
        end
    end

    // inc/dec already fold in the modulo wrap, so every mode can share "moved".
    always_comb begin
        terminal = up_dn ? MAX_VAL : '0;
        at_term  = (out == terminal);
        inc_val  = (out == MAX_VAL) ? '0 : out + WIDTH'(1);
        dec_val  = (out == '0) ? MAX_VAL : out - WIDTH'(1);
        moved    = up_dn ? inc_val : dec_val;
    end

    always_comb begin
        out_step  = out;
        tc_step   = 1'b0;
        done_step = done;
        case (mode)
            MODE_SAT: begin
                if (!at_term) begin
                    out_step = moved;
                    tc_step  = (moved == terminal);
                end
            end
            MODE_ONCE: begin
                if (!done) begin
                    if (at_term) begin
                        done_step = 1'b1;
                        tc_step   = 1'b1;
                    end else begin
                        out_step = moved;
                        if (moved == terminal) begin
                            done_step = 1'b1;
                            tc_step   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                out_step = moved;
                tc_step  = at_term;
            end
        endcase
    end

    always_comb begin
        load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out  <= '0;
            tc   <= 1'b0;
            done <= 1'b0;
            pcnt <= '0;
        end else if (clr) begin
            out  <= '0;
            tc   <= 1'b0;
            done <= 1'b0;
            pcnt <= '0;
        end else if (load) begin
            out  <= load_clamped;
            tc   <= 1'b0;
            done <= 1'b0;
            pcnt <= '0;
        end else begin
            pcnt <= pcnt_nxt;
            tc   <= step && tc_step;
            if (step) begin
                out  <= out_step;
                done <= done_step;
            end
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: two configurations driven in lockstep, a driver
// pushing model-predicted results into a queue, and a negedge monitor popping them.
module tb_param_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic       up_dn;
    logic [1:0] mode;

    logic [7:0] out_a, out_b;
    logic       tc_a, tc_b, done_a, done_b;

    int checks = 0;
    int errors = 0;

    // {out_a, tc_a, done_a, out_b, tc_b, done_b}
    logic [19:0] exp_q[$];

    // Reference model state; index 0 = dut_a, 1 = dut_b
    int m_cnt[2];
    int m_p[2];
    bit m_done[2];
    bit m_tc[2];
    int max_v[2] = '{9, 3};
    int ps_v[2]  = '{1, 4};

    always #5 clk = ~clk;

    param_counter #(.WIDTH(8), .MAX_VAL(8'd9), .PRESCALE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .up_dn(up_dn), .mode(mode),
        .out(out_a), .tc(tc_a), .done(done_a)
    );

    param_counter #(.WIDTH(8), .MAX_VAL(8'd3), .PRESCALE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .up_dn(up_dn), .mode(mode),
        .out(out_b), .tc(tc_b), .done(done_b)
    );

    // One step of the behavioural counter for configuration k.
    task automatic model_step(input int k);
        int mx;
        int n;
        int term;
        bit do_step;
        mx = max_v[k];
        n  = mx + 1;
        m_tc[k] = 1'b0;
        if (!rst_n || clr) begin
            m_cnt[k] = 0; m_p[k] = 0; m_done[k] = 1'b0;
        end else if (load) begin
            m_cnt[k]  = (int'(load_val) > mx) ? mx : int'(load_val);
            m_p[k]    = 0;
            m_done[k] = 1'b0;
        end else if (en) begin
            do_step = (m_p[k] == ps_v[k] - 1);
            m_p[k]  = do_step ? 0 : m_p[k] + 1;
            if (do_step) begin
                term = up_dn ? mx : 0;
                if (mode == 2'd1) begin
                    if (m_cnt[k] != term) begin
                        m_cnt[k] = up_dn ? m_cnt[k] + 1 : m_cnt[k] - 1;
                        m_tc[k]  = (m_cnt[k] == term);
                    end
                end else if (mode == 2'd2) begin
                    if (!m_done[k]) begin
                        if (m_cnt[k] != term)
                            m_cnt[k] = up_dn ? m_cnt[k] + 1 : m_cnt[k] - 1;
                        if (m_cnt[k] == term) begin
                            m_done[k] = 1'b1;
                            m_tc[k]   = 1'b1;
                        end
                    end
                end else begin
                    m_tc[k]  = (m_cnt[k] == term);
                    m_cnt[k] = up_dn ? (m_cnt[k] + 1) % n : (m_cnt[k] + n - 1) % n;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic c, input logic l, input logic e,
                         input logic u, input logic [1:0] m, input logic [7:0] lv);
        rst_n = r; clr = c; load = l; en = e; up_dn = u; mode = m; load_val = lv;
        model_step(0);
        model_step(1);
        exp_q.push_back({m_cnt[0][7:0], m_tc[0], m_done[0], m_cnt[1][7:0], m_tc[1], m_done[1]});
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [19:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_a",  out_a,         e[19:12]);
            check("tc_a",   {7'd0, tc_a},   {7'd0, e[11]});
            check("done_a", {7'd0, done_a}, {7'd0, e[10]});
            check("out_b",  out_b,         e[9:2]);
            check("tc_b",   {7'd0, tc_b},   {7'd0, e[1]});
            check("done_b", {7'd0, done_b}, {7'd0, e[0]});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic       r_u;
        logic [1:0] r_m;
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0;
        up_dn = 1'b1; mode = 2'd0; load_val = 8'd0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_p[i] = 0; m_done[i] = 1'b0; m_tc[i] = 1'b0;
        end

        // Reset
        cycle(0, 0, 0, 0, 1, 2'd0, 8'd0);
        cycle(0, 0, 0, 0, 1, 2'd0, 8'd0);
        // Wrap up through the terminal
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, 1, 1, 2'd0, 8'd0);
        // Wrap down from 0
        cycle(1, 1, 0, 0, 1, 2'd0, 8'd0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0, 2'd0, 8'd0);
        // Saturate up from a loaded 7
        cycle(1, 0, 1, 0, 1, 2'd1, 8'd7);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, 1, 2'd1, 8'd0);
        // One-shot up from 0, direction flip while done, then clear
        cycle(1, 1, 0, 0, 1, 2'd2, 8'd0);
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, 1, 1, 2'd2, 8'd0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, 0, 2'd2, 8'd0);
        cycle(1, 1, 0, 0, 1, 2'd2, 8'd0);
        // Prescaler with an enable gap
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 1, 1, 2'd0, 8'd0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 2'd0, 8'd0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 1, 1, 2'd0, 8'd0);
        // Reset beats clr/load/en mid-count; clamped load afterwards
        cycle(0, 1, 1, 1, 1, 2'd0, 8'd200);
        cycle(1, 0, 1, 0, 1, 2'd0, 8'd200);
        check("load_clamp_a", out_a, 8'd9);
        check("load_clamp_b", out_b, 8'd3);
        // Reserved mode behaves as wrap
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 1, 2'd3, 8'd0);

        // Randomised traffic
        r_u = 1'b1;
        r_m = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) r_u = ~r_u;
            if ($urandom_range(0, 31) == 0) r_m = 2'($urandom_range(0, 3));
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 3) != 0),
                  r_u, r_m, 8'($urandom_range(0, 255)));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
